// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared constants, encodings and decode helpers for the debug command receiver
package debug_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 104;
  localparam int ARG_NIBBLES          = 4;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_H_UC = 8'h48;
  localparam logic [7:0] ASCII_H_LC = 8'h68;
  localparam logic [7:0] ASCII_C_UC = 8'h43;
  localparam logic [7:0] ASCII_C_LC = 8'h63;
  localparam logic [7:0] ASCII_S_UC = 8'h53;
  localparam logic [7:0] ASCII_S_LC = 8'h73;
  localparam logic [7:0] ASCII_B_UC = 8'h42;
  localparam logic [7:0] ASCII_B_LC = 8'h62;
  localparam logic [7:0] ASCII_X_UC = 8'h58;
  localparam logic [7:0] ASCII_X_LC = 8'h78;

  typedef enum logic [1:0] {s_IDLE, s_ARG, s_WAIT_EOL, s_DISCARD} parse_state_t;

  typedef enum logic [2:0] {
    CMD_NONE, CMD_HALT, CMD_CONT, CMD_STEP, CMD_CLEAR, CMD_SETBP
  } cmd_t;

  // Returns {valid, value} for an ASCII hex digit in either case.
  function automatic logic [4:0] hex_nibble(input logic [7:0] ch);
    if (ch >= 8'h30 && ch <= 8'h39)
      return {1'b1, ch[3:0]};
    else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66))
      return {1'b1, ch[3:0] + 4'd9};
    else
      return 5'd0;
  endfunction

  // Maps a command letter (either case) to its encoding; CMD_NONE otherwise.
  function automatic cmd_t cmd_of(input logic [7:0] ch);
    if (ch == ASCII_H_UC || ch == ASCII_H_LC) return CMD_HALT;
    if (ch == ASCII_C_UC || ch == ASCII_C_LC) return CMD_CONT;
    if (ch == ASCII_S_UC || ch == ASCII_S_LC) return CMD_STEP;
    if (ch == ASCII_X_UC || ch == ASCII_X_LC) return CMD_CLEAR;
    if (ch == ASCII_B_UC || ch == ASCII_B_LC) return CMD_SETBP;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with glitch rejection and framing-error detection
module uart_rx
  import debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic       data_valid,
  output logic [7:0] data_byte,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            dv_d, fe_d;
  logic [1:0]      sync_q;
  logic            rx_s;

  assign rx_s      = sync_q[1];
  assign data_byte = shift_q;

  // Bring the asynchronous line into the clock domain; idles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], rx};
  end

  // Receiver state, bit timing counters and one-cycle status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      data_valid <= dv_d;
      frame_err  <= fe_d;
    end
  end

  // Frame sequencing: start-bit validation at half bit, then sample at bit centres.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = RX_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            dv_d    = 1'b1;
            state_d = RX_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/debug_cmd_rx.sv
// rtl/debug_cmd_rx.sv - debug console command parser driving halt, step and PC breakpoint
module debug_cmd_rx
  import debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  input  logic [15:0] pc,
  output logic        halt,
  output logic        step,
  output logic [15:0] bp_addr,
  output logic        bp_valid,
  output logic        cmd_error
);

  logic        dv;
  logic [7:0]  rx_byte;
  logic        frame_err;

  parse_state_t state_q, state_d;
  cmd_t         pend_q, pend_d, exec;
  logic [15:0]  arg_q, arg_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         bp_skip;
  logic         halt_d, step_d, bp_valid_d, skip_d, err_d;
  logic [15:0]  bp_addr_d;

  logic [4:0]   hex;
  cmd_t         byte_cmd;
  logic         is_eol, is_sp, hit;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .data_valid (dv),
    .data_byte  (rx_byte),
    .frame_err  (frame_err)
  );

  assign hex      = hex_nibble(rx_byte);
  assign byte_cmd = cmd_of(rx_byte);
  assign is_eol   = (rx_byte == ASCII_CR) || (rx_byte == ASCII_LF);
  assign is_sp    = (rx_byte == ASCII_SP);
  assign hit      = bp_valid && (pc == bp_addr) && !bp_skip;

  // Parser and control outputs; everything registered for a one-clock execute latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= s_IDLE;
      pend_q    <= CMD_NONE;
      arg_q     <= '0;
      cnt_q     <= '0;
      halt      <= 1'b0;
      step      <= 1'b0;
      bp_addr   <= '0;
      bp_valid  <= 1'b0;
      bp_skip   <= 1'b0;
      cmd_error <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      arg_q     <= arg_d;
      cnt_q     <= cnt_d;
      halt      <= halt_d;
      step      <= step_d;
      bp_addr   <= bp_addr_d;
      bp_valid  <= bp_valid_d;
      bp_skip   <= skip_d;
      cmd_error <= err_d;
    end
  end

  // Line grammar, command execution and breakpoint match; execution overrides a hit.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    arg_d      = arg_q;
    cnt_d      = cnt_q;
    exec       = CMD_NONE;
    err_d      = frame_err;
    step_d     = 1'b0;
    halt_d     = halt;
    bp_addr_d  = bp_addr;
    bp_valid_d = bp_valid;
    skip_d     = bp_skip && (pc == bp_addr);

    case (state_q)
      s_IDLE: begin
        if (dv && !is_eol && !is_sp) begin
          if (byte_cmd == CMD_NONE) begin
            err_d   = 1'b1;
            state_d = s_DISCARD;
          end else if (byte_cmd == CMD_SETBP) begin
            arg_d   = '0;
            cnt_d   = '0;
            state_d = s_ARG;
          end else begin
            pend_d  = byte_cmd;
            state_d = s_WAIT_EOL;
          end
        end
      end
      s_ARG: begin
        if (frame_err) begin
          state_d = s_DISCARD;
        end else if (dv && !(is_sp && cnt_q == 3'd0)) begin
          if (hex[4]) begin
            arg_d = {arg_q[11:0], hex[3:0]};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(ARG_NIBBLES - 1)) begin
              pend_d  = CMD_SETBP;
              state_d = s_WAIT_EOL;
            end
          end else begin
            err_d   = 1'b1;
            state_d = is_eol ? s_IDLE : s_DISCARD;
          end
        end
      end
      s_WAIT_EOL: begin
        if (frame_err) begin
          state_d = s_DISCARD;
        end else if (dv && !is_sp) begin
          if (is_eol) begin
            exec    = pend_q;
            state_d = s_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = s_DISCARD;
          end
        end
      end
      s_DISCARD: begin
        if (dv && is_eol) state_d = s_IDLE;
      end
      default: state_d = s_IDLE;
    endcase

    if (hit) halt_d = 1'b1;

    case (exec)
      CMD_HALT: halt_d = 1'b1;
      CMD_CONT: begin
        halt_d = 1'b0;
        skip_d = 1'b1;
      end
      CMD_STEP: begin
        if (halt) begin
          step_d = 1'b1;
          skip_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      CMD_CLEAR: bp_valid_d = 1'b0;
      CMD_SETBP: begin
        bp_addr_d  = arg_q;
        bp_valid_d = 1'b1;
        skip_d     = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_debug_cmd_rx.sv
// tb/tb_debug_cmd_rx.sv - scoreboard bench for the debug command receiver
module tb_debug_cmd_rx;

  localparam int CPB = 4;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic        halt, step, bp_valid, cmd_error;
  logic [15:0] bp_addr;

  typedef struct packed {
    logic        halt;
    logic        step;
    logic        bp_valid;
    logic        cmd_error;
    logic [15:0] bp_addr;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  debug_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .pc        (pc),
    .halt      (halt),
    .step      (step),
    .bp_addr   (bp_addr),
    .bp_valid  (bp_valid),
    .cmd_error (cmd_error)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic h, input logic s, input logic v, input logic e, input logic [15:0] a);
    ev_t ev;
    ev.halt = h; ev.step = s; ev.bp_valid = v; ev.cmd_error = e; ev.bp_addr = a;
    exp_q.push_back(ev);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(CPB);
    end
    rx = stop_bit;
    cycles(CPB);
    rx = 1'b1;
    cycles(CPB);
  endtask

  task automatic send_line(input string s, input logic [7:0] term);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    send_byte(term, 1'b1);
  endtask

  // Monitor: any level change or pulse on the outputs is one event popped from the scoreboard.
  ev_t prev;
  always @(negedge clk) begin
    ev_t cur;
    ev_t e;
    cur.halt = halt; cur.step = step; cur.bp_valid = bp_valid;
    cur.cmd_error = cmd_error; cur.bp_addr = bp_addr;
    if (reset_n) begin
      if (step || cmd_error || cur.halt !== prev.halt ||
          cur.bp_valid !== prev.bp_valid || cur.bp_addr !== prev.bp_addr) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got halt=%b step=%b bpv=%b err=%b addr=%h expected no event",
                   cur.halt, cur.step, cur.bp_valid, cur.cmd_error, cur.bp_addr);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL event: got halt=%b step=%b bpv=%b err=%b addr=%h expected halt=%b step=%b bpv=%b err=%b addr=%h",
                     cur.halt, cur.step, cur.bp_valid, cur.cmd_error, cur.bp_addr,
                     e.halt, e.step, e.bp_valid, e.cmd_error, e.bp_addr);
          end
        end
      end
    end
    prev = cur;
  end

  initial begin
    cycles(3);
    check("reset_outputs", {11'd0, halt, step, bp_valid, cmd_error, bp_addr}, 32'd0);
    reset_n = 1'b1;
    cycles(5);

    // Halt then continue
    push(1, 0, 0, 0, 16'h0000);
    send_line("H", CR);
    push(0, 0, 0, 0, 16'h0000);
    send_line("C", LF);
    cycles(10);

    // Arm breakpoint (lower-case, spaces) and hit it
    pc = 16'h019F;
    push(0, 0, 1, 0, 16'h01A0);
    send_line("b 01a0", CR);
    cycles(10);
    check("no_hit_at_019f", {31'd0, halt}, 32'd0);
    push(1, 0, 1, 0, 16'h01A0);
    pc = 16'h01A0;
    cycles(1);
    check("bp_hit_latency", {31'd0, halt}, 32'd1);

    // Single step from halt, then continue and re-hit
    push(1, 1, 1, 0, 16'h01A0);
    send_line("S", CR);
    cycles(20);
    check("halt_after_step", {31'd0, halt}, 32'd1);
    push(0, 0, 1, 0, 16'h01A0);
    send_line("C", CR);
    cycles(10);
    check("no_rehalt_after_c", {31'd0, halt}, 32'd0);
    push(1, 0, 1, 0, 16'h01A0);
    pc = 16'h01A1;
    cycles(3);
    check("no_hit_at_01a1", {31'd0, halt}, 32'd0);
    pc = 16'h01A0;
    cycles(1);
    check("rehit_latency", {31'd0, halt}, 32'd1);

    // Malformed lines
    pc = 16'h0000;
    cycles(2);
    push(0, 0, 1, 0, 16'h01A0);
    send_line("C", CR);
    push(0, 0, 1, 1, 16'h01A0);
    send_line("B 12", CR);
    push(0, 0, 1, 1, 16'h01A0);
    send_line("Q7", CR);
    push(1, 0, 1, 0, 16'h01A0);
    send_line("H", CR);
    push(1, 0, 0, 0, 16'h01A0);
    send_line("X", CR);
    push(0, 0, 0, 0, 16'h01A0);
    send_line("C", CR);
    cycles(10);

    // Framing error on 'H', then a bare CR
    push(0, 0, 0, 1, 16'h01A0);
    send_byte(8'h48, 1'b0);
    send_byte(CR, 1'b1);
    cycles(10);
    check("halt_after_frame_err", {31'd0, halt}, 32'd0);

    // One-clock glitch: no byte, no error
    rx = 1'b0;
    cycles(1);
    rx = 1'b1;
    cycles(30);

    // Arm and halt, then asynchronous reset mid-frame
    push(0, 0, 1, 0, 16'h1234);
    send_line("B1234", CR);
    push(1, 0, 1, 0, 16'h1234);
    send_line("H", CR);
    cycles(5);
    rx = 1'b0;
    cycles(6);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_halt", {31'd0, halt}, 32'd0);
    check("async_reset_bp", {15'd0, bp_valid, bp_addr}, 32'd0);
    check("async_reset_pulses", {30'd0, step, cmd_error}, 32'd0);
    rx = 1'b1;
    cycles(3);
    reset_n = 1'b1;
    cycles(5);
    push(1, 0, 0, 0, 16'h0000);
    send_line("H", CR);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) cycles(1);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
